// File: rtl/wave_pkg.sv
// Shared constants and types for the wave RAM playback block.
package wave_pkg;

    localparam int unsigned WAVE_AW      = 11;
    localparam int unsigned WAVE_DW      = 9;
    localparam int unsigned WAVE_DIV_W   = 16;
    localparam int unsigned RAM_READ_LAT = 1;

    typedef logic [WAVE_AW-1:0] addr_t;
    typedef logic [WAVE_DW-1:0] sample_t;

    // Tag travelling alongside each issued read until its data is captured.
    typedef struct packed {
        logic valid;
        logic is_end;
    } rd_tag_t;

endpackage

// File: rtl/rate_tick.sv
// Sample-rate divider: fires a tick every reload+1 clocks while run is high.
module rate_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = run & (cnt == '0);

    // Counter parks at zero while stopped so the first enabled cycle ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/wave_ram_player.sv
// Loop playback master for the single-port sample RAM, sharing the port
// with a host write channel; playback reads always take priority.
module wave_ram_player
    import wave_pkg::*;
#(
    parameter int unsigned AW       = WAVE_AW,
    parameter int unsigned DW       = WAVE_DW,
    parameter int unsigned DIV_W    = WAVE_DIV_W,
    parameter int unsigned READ_LAT = RAM_READ_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [AW-1:0]    loop_start,
    input  logic [AW-1:0]    loop_end,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    output logic             ram_ce,
    output logic             ram_oce,
    output logic             ram_wre,
    output logic [AW-1:0]    ram_ad,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout,
    output logic [DW-1:0]    sample,
    output logic             sample_valid,
    output logic             wrap
);

    logic                     tick;
    logic                     rd_issue;
    logic                     wr_accept;
    logic                     in_flight;
    logic                     is_end;
    logic [AW-1:0]            ptr;
    logic [AW-1:0]            end_q;
    rd_tag_t [READ_LAT-1:0]   pipe;

    rate_tick #(
        .DIV_W (DIV_W)
    ) u_rate_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .reload (rate_div),
        .tick   (tick)
    );

    // Qualifying with rst_n keeps the RAM port quiet while reset is held.
    assign rd_issue  = rst_n & tick;
    assign is_end    = (ptr == end_q);
    assign wr_ready  = rst_n & ~rd_issue & ~in_flight;
    assign wr_accept = wr_valid & wr_ready;
    assign ram_oce   = 1'b1;

    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < int'(READ_LAT); i++) begin
            in_flight = in_flight | pipe[i].valid;
        end
    end

    // Single RAM port mux: read tick first, then an accepted host write.
    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_ad  = '0;
        ram_din = '0;
        if (rd_issue) begin
            ram_ce = 1'b1;
            ram_ad = ptr;
        end else if (wr_accept) begin
            ram_ce  = 1'b1;
            ram_wre = 1'b1;
            ram_ad  = wr_addr;
            ram_din = wr_data;
        end
    end

    // Loop bounds are only picked up while stopped or on the wrap read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            end_q <= '0;
        end else if (!run) begin
            ptr   <= loop_start;
            end_q <= loop_end;
        end else if (rd_issue) begin
            if (is_end) begin
                ptr   <= loop_start;
                end_q <= loop_end;
            end else begin
                ptr <= ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= {rd_issue, is_end};
            for (int i = 1; i < int'(READ_LAT); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Capture RAM data when the matching tag reaches the end of the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            sample_valid <= pipe[READ_LAT-1].valid;
            wrap         <= pipe[READ_LAT-1].valid & pipe[READ_LAT-1].is_end;
            if (pipe[READ_LAT-1].valid) begin
                sample <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_wave_ram_player.sv
// Scoreboard bench for wave_ram_player with a behavioural bypass-read RAM.
module tb_wave_ram_player;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [10:0] loop_start;
    logic [10:0] loop_end;
    logic [15:0] rate_div;
    logic        wr_valid;
    logic        wr_ready;
    logic [10:0] wr_addr;
    logic [8:0]  wr_data;
    logic        ram_ce;
    logic        ram_oce;
    logic        ram_wre;
    logic [10:0] ram_ad;
    logic [8:0]  ram_din;
    logic [8:0]  ram_dout;
    logic [8:0]  sample;
    logic        sample_valid;
    logic        wrap;

    typedef struct {
        int unsigned cyc;
        logic [8:0]  data;
        logic        wrap;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc;
    int          n_tests;
    int          n_fail;
    logic [8:0]  mem [2048];

    wave_ram_player dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .loop_start   (loop_start),
        .loop_end     (loop_end),
        .rate_div     (rate_div),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .ram_ce       (ram_ce),
        .ram_oce      (ram_oce),
        .ram_wre      (ram_wre),
        .ram_ad       (ram_ad),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wrap         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPX9-style RAM, bypass mode, one clock of read latency.
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                mem[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
            end else begin
                ram_dout <= mem[ram_ad];
            end
        end
    end

    function automatic logic [8:0] init_val(input int a);
        return 9'(a + 256);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        n_tests++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    task automatic push(input int unsigned c, input logic [8:0] d, input logic w);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        e.wrap = w;
        sb.push_back(e);
    endtask

    // Program bounds with run low long enough for the pointer to load them.
    task automatic setup(input int s, input int e, input int r);
        @(posedge clk); #1;
        run        = 1'b0;
        loop_start = 11'(s);
        loop_end   = 11'(e);
        rate_div   = 16'(r);
        @(posedge clk); #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the head of the scoreboard in cycle,
    // data and wrap; an overdue head entry counts as a missed strobe.
    always @(negedge clk) begin
        if (!sample_valid) begin
            if (wrap) fail($sformatf("wrap_alone: wrap=1 without sample_valid at cycle %0d", cyc));
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                mon_e = sb.pop_front();
                fail($sformatf("missed_strobe: no sample_valid, required data %h at cycle %0d", mon_e.data, mon_e.cyc));
            end
        end else if (sb.size() == 0) begin
            fail($sformatf("unexpected_strobe: data %h wrap %b at cycle %0d, required none", sample, wrap, cyc));
        end else begin
            mon_e = sb.pop_front();
            n_tests++;
            if (cyc != mon_e.cyc || sample !== mon_e.data || wrap !== mon_e.wrap) begin
                n_fail++;
                $display("FAIL strobe: got cyc %0d data %h wrap %b, required cyc %0d data %h wrap %b",
                         cyc, sample, wrap, mon_e.cyc, mon_e.data, mon_e.wrap);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int          nw;
        int          ph;
        int          addrs [5];
        logic [39:0] exp_port;

        for (int k = 0; k < 2048; k++) mem[k] = init_val(k);
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        run        = 1'b0;
        loop_start = '0;
        loop_end   = '0;
        rate_div   = '0;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        #3;
        check("reset_outputs", {sample, sample_valid, wrap, wr_ready, ram_ce, ram_wre, ram_ad, ram_din}, '0);
        check("ram_oce", 64'(ram_oce), 64'd1);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(1);
        check("idle_ready", 64'(wr_ready), 64'd1);

        // Loop 4..6, period 3; run drops one cycle after the read at cycle 9.
        setup(4, 6, 2);
        c0 = cyc;
        run = 1'b1;
        push(c0 + 2,  9'h104, 1'b0);
        push(c0 + 5,  9'h105, 1'b0);
        push(c0 + 8,  9'h106, 1'b1);
        push(c0 + 11, 9'h104, 1'b0);
        wait_cycles(10);
        run = 1'b0;
        wait_cycles(8);

        // Full rate over the whole RAM, crossing the 2047 -> 0 wrap.
        setup(0, 2047, 0);
        c0 = cyc;
        run = 1'b1;
        for (int k = 0; k < 2051; k++) push(c0 + 2 + 32'(k), init_val(k % 2048), (k % 2048) == 2047);
        wait_cycles(2051);
        run = 1'b0;
        wait_cycles(4);

        // Host writes squeezed between reads of a period-4 loop.
        setup(4, 6, 3);
        c0 = cyc;
        run = 1'b1;
        wr_valid = 1'b1;
        nw = 0;
        push(c0 + 2,  9'h104, 1'b0);
        push(c0 + 6,  9'h105, 1'b0);
        push(c0 + 10, 9'h106, 1'b1);
        for (int i = 0; i < 12; i++) begin
            wr_addr = 11'(100 + nw);
            wr_data = 9'(160 + nw);
            #1;
            ph = i % 4;
            if (ph == 0)      exp_port = {1'b0, 1'b1, 1'b0, 11'(4 + i / 4), 9'h000};
            else if (ph == 1) exp_port = {1'b0, 1'b0, 1'b0, 11'h000, 9'h000};
            else              exp_port = {1'b1, 1'b1, 1'b1, 11'(100 + nw), 9'(160 + nw)};
            check($sformatf("arb_cycle%0d", i), 64'({wr_ready, ram_ce, ram_wre, ram_ad, ram_din}), 64'(exp_port));
            if (ph >= 2) nw++;
            @(posedge clk); #1;
        end
        run = 1'b0;
        wr_valid = 1'b0;
        wait_cycles(4);

        setup(100, 105, 0);
        c0 = cyc;
        run = 1'b1;
        for (int j = 0; j < 6; j++) push(c0 + 2 + 32'(j), 9'(160 + j), j == 5);
        wait_cycles(6);
        run = 1'b0;
        wait_cycles(4);

        // Reversed bounds wrap through the top of the address space.
        setup(2046, 1, 0);
        c0 = cyc;
        run = 1'b1;
        addrs = '{2046, 2047, 0, 1, 2046};
        for (int j = 0; j < 5; j++) push(c0 + 2 + 32'(j), init_val(addrs[j]), addrs[j] == 1);
        wait_cycles(5);
        run = 1'b0;
        wait_cycles(4);
        check("idle_port", 64'({ram_ce, ram_wre}), 64'd0);
        check("held_sample", 64'(sample), 64'(init_val(2046)));

        // Reset while a read is in flight: no capture, everything cleared.
        setup(4, 6, 5);
        run = 1'b1;
        wait_cycles(1);
        check("inflight_ready", 64'(wr_ready), 64'd0);
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("async_reset", {sample, sample_valid, wrap, wr_ready, ram_ce, ram_wre, ram_ad, ram_din}, '0);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(6);
        check("post_reset_sample", 64'(sample), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_ram_player.md
Name: wave_ram_player

Overview:
- Playback master for the 2048x9 single-port sample RAM (SPX9, bypass read, one clock of read latency).
- Reads samples sequentially from loop_start to loop_end, wrapping back to loop_start, at a programmable sample rate.
- Presents each sample with a one-cycle valid strobe to the DAC/PWM stage.
- Arbitrates the single RAM port between playback reads and host write requests, for example from the UART loader.

Parameters:
- AW, 11: RAM address width.
- DW, 9: sample / RAM data width.
- DIV_W, 16: width of the rate divider.
- READ_LAT, 1: RAM clocks from CE (read) to valid dout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = playback enabled.
- loop_start  in  AW  first address of the loop.
- loop_end  in  AW  last address of the loop, inclusive.
- rate_div  in  DIV_W  sample period in clocks minus 1.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write accepted this cycle.
- wr_addr  in  AW  host write address.
- wr_data  in  DW  host write data.
- ram_ce  out  1  RAM clock enable.
- ram_oce  out  1  RAM output clock enable; constant 1.
- ram_wre  out  1  RAM write enable.
- ram_ad  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data.
- sample  out  DW  last captured sample; held between strobes.
- sample_valid  out  1  one-cycle strobe, new sample.
- wrap  out  1  one-cycle strobe, coincident with the sample_valid of the loop_end sample.

Behaviour:
- Reset (async, rst_n=0):
  - ptr=0, div_cnt=0, pipeline cleared.
  - sample=0, sample_valid=0, wrap=0, wr_ready=0.
  - ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
- run=0:
  - div_cnt held at 0.
  - ptr loads loop_start every cycle.
  - No new reads. Reads already in flight still complete and still strobe sample_valid.
- run=1, div_cnt==0 (read issue, rd_issue=1):
  - ram_ce=1, ram_wre=0, ram_ad=ptr.
  - div_cnt<=rate_div.
  - ptr<=loop_start if ptr==loop_end, else ptr+1 mod 2^AW.
- run=1, div_cnt!=0: div_cnt decrements by 1.
- Timing:
  - First read is issued in the first cycle run is sampled high.
  - Read period is rate_div+1 clocks. rate_div=0 gives a read every clock.
- Read pipeline:
  - A READ_LAT-deep shift register carries {valid, is_end} for each issued read.
  - The RAM output is registered into sample at the end of cycle t+READ_LAT.
  - sample_valid and wrap are high in cycle t+READ_LAT+1 for a read issued in cycle t.
  - Back-to-back reads are supported.
- Loop bounds:
  - loop_start and loop_end are sampled only when the pointer is at loop_end or when run=0. Mid-loop changes take effect at the next wrap.
  - If loop_end < loop_start, ptr counts up through 2^AW-1, wraps to 0, and continues to loop_end.
  - If loop_start==loop_end, the same address is read every period and every sample strobes wrap.
- Host write port:
  - wr_ready = ~rd_issue & ~(any read in flight). It does not depend on wr_valid.
  - A write is accepted when wr_valid & wr_ready. In that same cycle: ram_ce=1, ram_wre=1, ram_ad=wr_addr, ram_din=wr_data.
  - Playback reads always win; a write never delays a read tick.
  - With run=1 and rate_div=0, writes starve. This is the intended behaviour.
- Idle port: ram_ce=0 and ram_wre=0 whenever neither a read nor a write occurs.
- Reset mid-read: the pending sample is discarded and no strobe is produced after reset.

Decomposition:
- Package wave_pkg:
  - constants WAVE_AW=11, WAVE_DW=9, RAM_READ_LAT=1.
  - types addr_t and sample_t.
- Sub-module rate_tick: DIV_W down-counter with enable and reload. Output tick = run & (cnt==0). Cleared while run=0.
- The port mux and the read pipeline stay in the top module.

Test Plan:
- Loop and wrap: RAM preloaded with mem[k]=k+0x100; loop_start=4, loop_end=6, rate_div=2; run rises at cycle 0.
  - Reads occur at cycles 0/3/6/9 at addresses 4/5/6/4.
  - sample_valid occurs at cycles 2/5/8/11 with sample 0x104/0x105/0x106/0x104.
  - wrap is high only at cycle 8.
- Full rate: rate_div=0, loop 0..2047. sample_valid stays high continuously with incrementing data. After address 2047 the next sample is mem[0], and wrap is coincident with the mem[2047] sample.
- Write arbitration: wr_valid held high with rate_div=3, run=1.
  - wr_ready=0 in the read-issue cycle and the following in-flight cycle.
  - wr_ready=1 in the other 2 cycles of each 4-cycle period.
  - Written addresses read back correctly after run=0.
- Reversed bounds: loop_start=2046, loop_end=1, rate_div=0. Address sequence is 2046, 2047, 0, 1, 2046, and wrap accompanies the address-1 sample.
- Stop and reset: deassert run one cycle after a read. That sample is still strobed, then no further strobes occur. Assert rst_n=0 while a read is in flight: sample=0, no strobe, all outputs 0 asynchronously.
